oam_dma_controller: RTL and testbench

OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

---
 rtl/oam_dma_controller.sv | 153 +++++++++++++++
 tb/tb_oam_dma_controller.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: copies one 256-byte CPU page to the OAM data port 16'h2004.
// Define OAM_DMA_ALIGN_EN to add the read/write parity alignment cycle.
module oam_dma_controller (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clk_en,
    input  logic        i_cpu_rw,
    input  logic [15:0] i_cpu_address,
    input  logic [7:0]  i_cpu_data,
    input  logic [7:0]  i_data,
    output logic        o_rdy,
    output logic        o_bus_owner,
    output logic [15:0] o_address,
    output logic [7:0]  o_data,
    output logic        o_rw,
    output logic        o_busy
);

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_DATA = 16'h2004;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
`ifdef OAM_DMA_ALIGN_EN
        ALIGN = 3'd2,
`endif
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] page_q;
    logic [7:0] idx_q;
    logic [7:0] data_q;
    logic       trigger;

    assign trigger = !i_cpu_rw && (i_cpu_address == DMA_REG);

`ifdef OAM_DMA_ALIGN_EN
    logic parity_q;

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            parity_q <= 1'b0;
        end else if (i_clk_en) begin
            parity_q <= ~parity_q;
        end
    end
`endif

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else if (i_clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                // A CPU write cycle cannot be stalled; wait for a read.
                if (i_cpu_rw) begin
`ifdef OAM_DMA_ALIGN_EN
                    state_d = parity_q ? READ : ALIGN;
`else
                    state_d = READ;
`endif
                end
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: begin
                state_d = READ;
            end
`endif
            READ: begin
                state_d = WRITE;
            end
            WRITE: begin
                state_d = (idx_q == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            page_q <= 8'h00;
            idx_q  <= 8'h00;
            data_q <= 8'h00;
        end else if (i_clk_en) begin
            if (state_q == IDLE && trigger) begin
                page_q <= i_cpu_data;
                idx_q  <= 8'h00;
            end
            if (state_q == READ) begin
                data_q <= i_data;
            end
            if (state_q == WRITE) begin
                idx_q <= idx_q + 8'd1;
            end
        end
    end

    always_comb begin
        o_rdy       = 1'b1;
        o_bus_owner = 1'b0;
        o_rw        = 1'b1;
        o_address   = 16'h0000;
        o_data      = 8'h00;
        unique case (state_q)
            IDLE: begin
                o_rdy = 1'b1;
            end
            HALT: begin
                o_rdy = 1'b0;
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: begin
                o_rdy = 1'b0;
            end
`endif
            READ: begin
                o_rdy       = 1'b0;
                o_bus_owner = 1'b1;
                o_address   = {page_q, idx_q};
            end
            WRITE: begin
                o_rdy       = 1'b0;
                o_bus_owner = 1'b1;
                o_rw        = 1'b0;
                o_address   = OAM_DATA;
                o_data      = data_q;
            end
            default: begin
                o_rdy = 1'b1;
            end
        endcase
    end

    assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: expected bus traffic queued at
// trigger/read time, observed traffic queued by the cycle monitor.
module tb_oam_dma_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        cpu_rw;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data;
    logic [7:0]  bus_data;
    logic        rdy;
    logic        owner;
    logic [15:0] address;
    logic [7:0]  data;
    logic        rw;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic        par;
    int          ticks;
    int          first_rd;
    int          rdy_low;
    int          bad_par;
    logic [15:0] exp_ra[$];
    logic [7:0]  exp_wd[$];
    logic [15:0] obs_ra[$];
    logic [15:0] obs_wa[$];
    logic [7:0]  obs_wd[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8] ^ 8'h3C;
    endfunction

    assign bus_data = mem(address);

    oam_dma_controller dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_clk_en      (clk_en),
        .i_cpu_rw      (cpu_rw),
        .i_cpu_address (cpu_address),
        .i_cpu_data    (cpu_data),
        .i_data        (bus_data),
        .o_rdy         (rdy),
        .o_bus_owner   (owner),
        .o_address     (address),
        .o_data        (data),
        .o_rw          (rw),
        .o_busy        (busy)
    );

    // Inputs change at posedge+1; DUT state moves on negedge; sample at posedge.
    task automatic tick();
        logic en;
        en = clk_en && reset_n;
        @(posedge clk);
        if (en) par = ~par;
        ticks++;
        if (!rdy) rdy_low++;
        if (reset_n && clk_en && owner) begin
            if (rw) begin
                obs_ra.push_back(address);
                exp_wd.push_back(mem(address));
                if (first_rd < 0) first_rd = ticks;
                if (par) bad_par++;
            end else begin
                obs_wa.push_back(address);
                obs_wd.push_back(data);
            end
        end
        #1;
    endtask

    task automatic start_stats();
        exp_ra.delete();
        exp_wd.delete();
        obs_ra.delete();
        obs_wa.delete();
        obs_wd.delete();
        ticks    = 0;
        first_rd = -1;
        rdy_low  = 0;
        bad_par  = 0;
    endtask

    task automatic idle_cpu();
        cpu_rw      = 1'b1;
        cpu_address = 16'h8000;
        cpu_data    = 8'h00;
    endtask

    task automatic trigger(input logic [7:0] page);
        logic [7:0] i8;
        cpu_rw      = 1'b0;
        cpu_address = 16'h4014;
        cpu_data    = page;
        for (int i = 0; i < 256; i++) begin
            i8 = i[7:0];
            exp_ra.push_back({page, i8});
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            $display("FAIL %s_timeout: busy=%b required 0", name, busy);
            fails++;
        end
        tests++;
        if (rdy !== 1'b1) begin
            $display("FAIL %s_rdy_end: rdy=%b required 1", name, rdy);
            fails++;
        end
    endtask

    task automatic check_sb(input string name);
        logic [15:0] a;
        logic [15:0] e;
        logic [7:0]  d;
        logic [7:0]  ed;
        tests++;
        if (obs_ra.size() !== exp_ra.size()) begin
            $display("FAIL %s_reads: got %0d required %0d", name,
                     obs_ra.size(), exp_ra.size());
            fails++;
        end
        tests++;
        if (obs_wd.size() !== exp_wd.size()) begin
            $display("FAIL %s_writes: got %0d required %0d", name,
                     obs_wd.size(), exp_wd.size());
            fails++;
        end
        while (obs_ra.size() > 0 && exp_ra.size() > 0) begin
            a = obs_ra.pop_front();
            e = exp_ra.pop_front();
            tests++;
            if (a !== e) begin
                $display("FAIL %s_raddr: got %h required %h", name, a, e);
                fails++;
            end
        end
        while (obs_wd.size() > 0 && exp_wd.size() > 0) begin
            d  = obs_wd.pop_front();
            ed = exp_wd.pop_front();
            a  = obs_wa.pop_front();
            tests++;
            if (d !== ed || a !== 16'h2004) begin
                $display("FAIL %s_write: got %h@%h required %h@2004",
                         name, d, a, ed);
                fails++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        tests++;
        if ({rdy, owner, rw, busy} !== 4'b1010) begin
            $display("FAIL reset_ctl: got %b required 1010",
                     {rdy, owner, rw, busy});
            fails++;
        end
        tests++;
        if (address !== 16'h0000 || data !== 8'h00) begin
            $display("FAIL reset_bus: got %h/%h required 0000/00",
                     address, data);
            fails++;
        end
        @(posedge clk);
        #1;
        start_stats();
        par     = 1'b0;
        reset_n = 1'b1;
        clk_en  = 1'b1;
        trigger(8'h33);
        tick();
        idle_cpu();
        tests++;
        if (busy !== 1'b1 || rdy !== 1'b0) begin
            $display("FAIL reset_release_trigger: busy=%b rdy=%b required 1/0",
                     busy, rdy);
            fails++;
        end
        wait_idle("reset_release");
        check_sb("reset_release");
    endtask

    task automatic test_basic();
        start_stats();
        trigger(8'h02);
        tick();
        idle_cpu();
        tests++;
        if (rdy !== 1'b0 || owner !== 1'b0) begin
            $display("FAIL basic_halt: rdy=%b owner=%b required 0/0",
                     rdy, owner);
            fails++;
        end
        wait_idle("basic");
        tests++;
`ifdef OAM_DMA_ALIGN_EN
        if (rdy_low != 513 && rdy_low != 514) begin
`else
        if (rdy_low != 513) begin
`endif
            $display("FAIL basic_span: got %0d required 513", rdy_low);
            fails++;
        end
        check_sb("basic");
    endtask

    task automatic test_cpu_writes();
        start_stats();
        trigger(8'h11);
        tick();
        cpu_rw      = 1'b0;
        cpu_address = 16'h0300;
        cpu_data    = 8'hA5;
        repeat (3) tick();
        idle_cpu();
        wait_idle("cpu_writes");
        tests++;
`ifdef OAM_DMA_ALIGN_EN
        if (first_rd != 5 && first_rd != 6) begin
`else
        if (first_rd != 5) begin
`endif
            $display("FAIL cpu_writes_first_read: got %0d required 5",
                     first_rd);
            fails++;
        end
        check_sb("cpu_writes");
    endtask

    task automatic test_clk_en_freeze();
        logic [15:0] a0;
        logic [3:0]  c0;
        int          n;
        start_stats();
        trigger(8'h02);
        tick();
        idle_cpu();
        n = 0;
        while (obs_ra.size() < 'h41 && n < 1000) begin
            tick();
            n++;
        end
        tests++;
        if (address !== 16'h0240) begin
            $display("FAIL freeze_point: got %h required 0240", address);
            fails++;
        end
        clk_en = 1'b0;
        a0 = address;
        c0 = {rdy, owner, rw, busy};
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (address !== a0 || {rdy, owner, rw, busy} !== c0) begin
                $display("FAIL freeze_hold%0d: got %h/%b required %h/%b",
                         k, address, {rdy, owner, rw, busy}, a0, c0);
                fails++;
            end
        end
        clk_en = 1'b1;
        wait_idle("freeze");
        tests++;
`ifdef OAM_DMA_ALIGN_EN
        if (rdy_low != 518 && rdy_low != 519) begin
`else
        if (rdy_low != 518) begin
`endif
            $display("FAIL freeze_span: got %0d required 518", rdy_low);
            fails++;
        end
        check_sb("freeze");
    endtask

    task automatic test_retrigger();
        start_stats();
        trigger(8'h02);
        tick();
        idle_cpu();
        repeat (100) tick();
        cpu_rw      = 1'b0;
        cpu_address = 16'h4014;
        cpu_data    = 8'h05;
        tick();
        idle_cpu();
        wait_idle("retrigger");
        check_sb("retrigger");
    endtask

    task automatic test_back_to_back();
        start_stats();
        trigger(8'hC3);
        tick();
        idle_cpu();
        wait_idle("b2b_first");
        trigger(8'hFF);
        tick();
        idle_cpu();
        wait_idle("b2b_second");
        check_sb("b2b");
    endtask

    task automatic test_reset_mid();
        int n;
        start_stats();
        trigger(8'h02);
        tick();
        idle_cpu();
        n = 0;
        while (obs_ra.size() < 'h81 && n < 1000) begin
            tick();
            n++;
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({rdy, owner, rw, busy} !== 4'b1010 || address !== 16'h0000) begin
            $display("FAIL reset_mid_outputs: got %b/%h required 1010/0000",
                     {rdy, owner, rw, busy}, address);
            fails++;
        end
        repeat (3) tick();
        par     = 1'b0;
        reset_n = 1'b1;
        repeat (20) tick();
        tests++;
        if (obs_ra.size() !== 'h81 || obs_wd.size() !== 'h80) begin
            $display("FAIL reset_mid_traffic: got %0d/%0d required 129/128",
                     obs_ra.size(), obs_wd.size());
            fails++;
        end
        while (exp_ra.size() > 'h81) void'(exp_ra.pop_back());
        void'(exp_wd.pop_back());
        check_sb("reset_mid");
    endtask

`ifdef OAM_DMA_ALIGN_EN
    task automatic test_parity_align();
        int span[2];
        start_stats();
        for (int p = 0; p < 2; p++) begin
            if (par !== p[0]) tick();
            rdy_low = 0;
            trigger(8'h40 + p[7:0]);
            tick();
            idle_cpu();
            wait_idle("align");
            span[p] = rdy_low;
        end
        tests++;
        if (span[1] - span[0] != 1) begin
            $display("FAIL align_span_delta: got %0d/%0d required diff 1",
                     span[0], span[1]);
            fails++;
        end
        tests++;
        if (bad_par != 0) begin
            $display("FAIL align_read_parity: got %0d odd reads required 0",
                     bad_par);
            fails++;
        end
        check_sb("align");
    endtask
`endif

    initial begin
        reset_n = 1'b1;
        clk_en  = 1'b0;
        par     = 1'b0;
        idle_cpu();
        start_stats();
        #2;
        test_reset();
        test_basic();
        test_cpu_writes();
        test_clk_en_freeze();
        test_retrigger();
        test_back_to_back();
        test_reset_mid();
`ifdef OAM_DMA_ALIGN_EN
        test_parity_align();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
